// File: rtl/noc_pkg.sv
// Shared definitions for the NoC injector: default geometry, word field offsets
// and the egress state encoding.
package noc_pkg;
  localparam int BIT_WIDTH = 16;
  localparam int LOG_N_ADD = 6;
  localparam int CTRL_BIT  = 1;
  localparam int LOG_DEPTH = 2;
  localparam int CNT_WIDTH = 16;

  localparam int W        = BIT_WIDTH + LOG_N_ADD + CTRL_BIT;
  localparam int DATA_LSB = 0;
  localparam int ADDR_LSB = BIT_WIDTH;
  localparam int VAL_POS  = W - 1;

  typedef enum logic {
    EMPTY  = 1'b0,
    LOADED = 1'b1
  } egress_state_t;
endpackage

// File: rtl/inj_fifo.sv
// Single-clock show-ahead FIFO; the level counter separates full from empty
// because the pointers wrap modulo depth.
module inj_fifo #(
  parameter int width     = 22,
  parameter int log_depth = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [width-1:0]     wr_data,
  input  logic                 rd_en,
  output logic [width-1:0]     rd_data,
  output logic [log_depth:0]   level,
  output logic                 full,
  output logic                 empty
);
  localparam int depth = 1 << log_depth;
  localparam logic [log_depth:0] depth_c = (log_depth + 1)'(depth);

  logic [width-1:0]     mem_r [depth];
  logic [log_depth-1:0] wr_ptr_r;
  logic [log_depth-1:0] rd_ptr_r;
  logic [log_depth:0]   level_r;
  logic                 do_wr_s;
  logic                 do_rd_s;

  assign full    = (level_r == depth_c);
  assign empty   = (level_r == {(log_depth + 1){1'b0}});
  assign level   = level_r;
  assign rd_data = mem_r[rd_ptr_r];
  assign do_wr_s = wr_en && !full;
  assign do_rd_s = rd_en && !empty;

  // Storage array write port
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {log_depth{1'b0}};
      rd_ptr_r <= {log_depth{1'b0}};
      level_r  <= {(log_depth + 1){1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + log_depth'(1);
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + log_depth'(1);
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   level_r <= level_r + (log_depth + 1)'(1);
        2'b01:   level_r <= level_r - (log_depth + 1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end
endmodule

// File: rtl/noc_injector.sv
// Per-multiplier NoC ingress: buffers products, presents {val, addr, data} on
// pkt until the NoC is not stalled, and counts transfers and stalled cycles.
module noc_injector
  import noc_pkg::*;
#(
  parameter int bit_width = BIT_WIDTH,
  parameter int log_n_add = LOG_N_ADD,
  parameter int ctrl_bit  = CTRL_BIT,
  parameter int log_depth = LOG_DEPTH,
  parameter int cnt_width = CNT_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  prod_valid,
  input  logic [bit_width-1:0]                  prod_data,
  input  logic [log_n_add-1:0]                  prod_addr,
  output logic                                  prod_ready,
  output logic [bit_width+log_n_add+ctrl_bit-1:0] pkt,
  input  logic                                  stall,
  output logic [log_depth:0]                    fifo_level,
  output logic [cnt_width-1:0]                  sent_cnt,
  output logic [cnt_width-1:0]                  stall_cnt
);
  localparam int pw = bit_width + log_n_add;
  localparam int ww = pw + ctrl_bit;

  egress_state_t    state_r;
  egress_state_t    state_nxt_s;
  logic [ww-1:0]    pkt_r;
  logic [ww-1:0]    pkt_nxt_s;
  logic [pw-1:0]    head_s;
  logic             pop_s;
  logic             xfer_s;
  logic             wr_en_s;
  logic             full_s;
  logic             empty_s;
  logic [cnt_width-1:0] sent_r;
  logic [cnt_width-1:0] stall_cnt_r;

  // Gating with rst keeps prod_ready low while reset is held.
  assign prod_ready = rst && !full_s;
  assign wr_en_s    = prod_valid && prod_ready;

  inj_fifo #(
    .width     (pw),
    .log_depth (log_depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .wr_data ({prod_addr, prod_data}),
    .rd_en   (pop_s),
    .rd_data (head_s),
    .level   (fifo_level),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Egress next-state, pop and output word selection
  always_comb begin
    state_nxt_s = state_r;
    pkt_nxt_s   = pkt_r;
    pop_s       = 1'b0;
    xfer_s      = 1'b0;
    case (state_r)
      EMPTY: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          pkt_nxt_s   = {{(ctrl_bit - 1){1'b0}}, 1'b1, head_s};
          state_nxt_s = LOADED;
        end else begin
          pkt_nxt_s   = {ww{1'b0}};
          state_nxt_s = EMPTY;
        end
      end
      LOADED: begin
        if (!stall) begin
          xfer_s = 1'b1;
          if (!empty_s) begin
            pop_s       = 1'b1;
            pkt_nxt_s   = {{(ctrl_bit - 1){1'b0}}, 1'b1, head_s};
            state_nxt_s = LOADED;
          end else begin
            pkt_nxt_s   = {ww{1'b0}};
            state_nxt_s = EMPTY;
          end
        end else begin
          pkt_nxt_s   = pkt_r;
          state_nxt_s = LOADED;
        end
      end
      default: begin
        pkt_nxt_s   = {ww{1'b0}};
        state_nxt_s = EMPTY;
      end
    endcase
  end

  // Egress state and output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= EMPTY;
      pkt_r   <= {ww{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      pkt_r   <= pkt_nxt_s;
    end
  end

  // Statistics: sent wraps, stall saturates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sent_r      <= {cnt_width{1'b0}};
      stall_cnt_r <= {cnt_width{1'b0}};
    end else begin
      if (xfer_s) begin
        sent_r <= sent_r + cnt_width'(1);
      end
      if ((state_r == LOADED) && stall && (stall_cnt_r != {cnt_width{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + cnt_width'(1);
      end
    end
  end

  assign pkt       = pkt_r;
  assign sent_cnt  = sent_r;
  assign stall_cnt = stall_cnt_r;
endmodule
